// File: rtl/if_pc_gen_pkg.sv
// Shared fetch-stage constants: reset vector, FSM encoding and the buffered slot payload.
package if_pc_gen_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h1C00_0000;

  typedef enum logic [1:0] {
    FS_REQ  = 2'd0,
    FS_WAIT = 2'd1,
    FS_HOLD = 2'd2
  } fs_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic            adef;
  } fs_slot_t;

  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/if_inst_buf.sv
// Holds the instruction slot (pc, word, adef) offered to decode while the fetch FSM is in HOLD.
module if_inst_buf
  import if_pc_gen_pkg::*;
(
  input  logic     clk,
  input  logic     resetn,
  input  logic     load,
  input  fs_slot_t slot_in,
  output fs_slot_t slot
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      slot <= '0;
    end else if (load) begin
      slot <= slot_in;
    end
  end

endmodule

// File: rtl/if_pc_gen.sv
// Fetch PC generator: one outstanding SRAM request, branch redirect with response cancel,
// misaligned-target exception slot, single-entry hold buffer towards decode.
module if_pc_gen
  import if_pc_gen_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  input  logic            ds_allowin,
  output logic            inst_sram_req,
  output logic [XLEN-1:0] inst_sram_addr,
  input  logic            inst_sram_addr_ok,
  input  logic            inst_sram_data_ok,
  input  logic [XLEN-1:0] inst_sram_rdata,
  output logic            fs_to_ds_valid,
  output logic [XLEN-1:0] fs_pc,
  output logic [XLEN-1:0] fs_inst,
  output logic            fs_adef
);

  fs_state_e       state_q, state_n;
  logic            req_q, req_n;
  logic [XLEN-1:0] addr_q, addr_n;
  logic            pend_q, pend_n;
  logic [XLEN-1:0] tgt_q, tgt_n;
  logic            cancel_q, cancel_n;

  logic            pend_eff;
  logic [XLEN-1:0] tgt_eff;
  logic            launch;
  logic            buf_load;
  fs_slot_t        buf_in;
  fs_slot_t        slot;

  // A redirect arriving this cycle overrides any older pending target.
  assign pend_eff = pend_q | br_taken;
  assign tgt_eff  = br_taken ? br_target : tgt_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= FS_REQ;
      req_q    <= 1'b0;
      addr_q   <= RESET_PC;
      pend_q   <= 1'b0;
      tgt_q    <= '0;
      cancel_q <= 1'b0;
    end else begin
      state_q  <= state_n;
      req_q    <= req_n;
      addr_q   <= addr_n;
      pend_q   <= pend_n;
      tgt_q    <= tgt_n;
      cancel_q <= cancel_n;
    end
  end

  always_comb begin
    state_n  = state_q;
    req_n    = req_q;
    addr_n   = addr_q;
    pend_n   = pend_q;
    tgt_n    = tgt_q;
    cancel_n = cancel_q;
    launch   = 1'b0;
    buf_load = 1'b0;
    buf_in   = '{pc: addr_q, inst: inst_sram_rdata, adef: 1'b0};

    if (br_taken) begin
      pend_n = 1'b1;
      tgt_n  = br_target;
    end

    case (state_q)
      FS_REQ: begin
        if (!req_q) begin
          if (pend_eff) launch = 1'b1;
          else          req_n  = 1'b1;
        end else if (inst_sram_addr_ok) begin
          // Accepting a stale address: its response must be thrown away.
          state_n  = FS_WAIT;
          req_n    = 1'b0;
          cancel_n = pend_eff;
        end
      end
      FS_WAIT: begin
        if (inst_sram_data_ok) begin
          if (cancel_q || br_taken) begin
            launch = 1'b1;
          end else begin
            buf_load = 1'b1;
            state_n  = FS_HOLD;
          end
        end else if (br_taken) begin
          cancel_n = 1'b1;
        end
      end
      FS_HOLD: begin
        if (br_taken) begin
          launch = 1'b1;
        end else if (ds_allowin) begin
          state_n = FS_REQ;
          req_n   = 1'b1;
          addr_n  = addr_q + 32'd4;
        end
      end
      default: state_n = FS_REQ;
    endcase

    // Start the redirected fetch, or build the adef slot without touching the SRAM.
    if (launch) begin
      pend_n   = 1'b0;
      cancel_n = 1'b0;
      addr_n   = tgt_eff;
      if (is_misaligned(tgt_eff)) begin
        state_n  = FS_HOLD;
        req_n    = 1'b0;
        buf_load = 1'b1;
        buf_in   = '{pc: tgt_eff, inst: 32'd0, adef: 1'b1};
      end else begin
        state_n = FS_REQ;
        req_n   = 1'b1;
      end
    end
  end

  if_inst_buf u_inst_buf (
    .clk     (clk),
    .resetn  (resetn),
    .load    (buf_load),
    .slot_in (buf_in),
    .slot    (slot)
  );

  assign inst_sram_req  = req_q;
  assign inst_sram_addr = addr_q;
  assign fs_to_ds_valid = (state_q == FS_HOLD) && !br_taken;
  assign fs_pc          = slot.pc;
  assign fs_inst        = slot.inst;
  assign fs_adef        = slot.adef;

endmodule

// File: tb/tb_if_pc_gen.sv
// Directed bench for if_pc_gen: reset, redirects in each state, back-to-back branches,
// misaligned target, decode backpressure and reset during an outstanding request.
module tb_if_pc_gen;

  logic        clk = 1'b0;
  logic        resetn;
  logic        br_taken;
  logic [31:0] br_target;
  logic        ds_allowin;
  logic        inst_sram_req;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        fs_to_ds_valid;
  logic [31:0] fs_pc;
  logic [31:0] fs_inst;
  logic        fs_adef;

  int n_checks = 0;
  int n_fail   = 0;
  bit seen_200 = 1'b0;

  always #5 clk = ~clk;

  if_pc_gen #(.RESET_PC(32'h1C00_0000)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .br_taken          (br_taken),
    .br_target         (br_target),
    .ds_allowin        (ds_allowin),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata),
    .fs_to_ds_valid    (fs_to_ds_valid),
    .fs_pc             (fs_pc),
    .fs_inst           (fs_inst),
    .fs_adef           (fs_adef)
  );

  // Watches for any request to the overwritten branch target.
  always @(negedge clk) begin
    if (resetn && inst_sram_req && inst_sram_addr == 32'h1C00_0200) seen_200 = 1'b1;
  end

  task automatic test_reset();
    resetn = 1'b0; br_taken = 1'b0; br_target = '0; ds_allowin = 1'b0;
    inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b0; inst_sram_rdata = '0;
    repeat (2) @(negedge clk);
    n_checks++; if (inst_sram_req !== 1'b0) begin n_fail++; $display("FAIL rst_req got %0h exp 0", inst_sram_req); end
    n_checks++; if (fs_to_ds_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %0h exp 0", fs_to_ds_valid); end
    n_checks++; if (fs_pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc got %0h exp 0", fs_pc); end
    n_checks++; if (fs_inst !== 32'h0) begin n_fail++; $display("FAIL rst_inst got %0h exp 0", fs_inst); end
    n_checks++; if (fs_adef !== 1'b0) begin n_fail++; $display("FAIL rst_adef got %0h exp 0", fs_adef); end
    resetn = 1'b1; inst_sram_addr_ok = 1'b1; ds_allowin = 1'b1;
    @(negedge clk);
    n_checks++; if (inst_sram_req !== 1'b1) begin n_fail++; $display("FAIL boot_req got %0h exp 1", inst_sram_req); end
    n_checks++; if (inst_sram_addr !== 32'h1C00_0000) begin n_fail++; $display("FAIL boot_addr got %0h exp 1c000000", inst_sram_addr); end
    @(negedge clk);
    inst_sram_addr_ok = 1'b0;
    n_checks++; if (inst_sram_req !== 1'b0) begin n_fail++; $display("FAIL boot_wait_req got %0h exp 0", inst_sram_req); end
    @(negedge clk);
    inst_sram_data_ok = 1'b1; inst_sram_rdata = 32'h0280_0421;
    @(negedge clk);
    inst_sram_data_ok = 1'b0;
    n_checks++; if (fs_to_ds_valid !== 1'b1) begin n_fail++; $display("FAIL boot_valid got %0h exp 1", fs_to_ds_valid); end
    n_checks++; if (fs_pc !== 32'h1C00_0000) begin n_fail++; $display("FAIL boot_pc got %0h exp 1c000000", fs_pc); end
    n_checks++; if (fs_inst !== 32'h0280_0421) begin n_fail++; $display("FAIL boot_inst got %0h exp 02800421", fs_inst); end
    @(negedge clk);
    n_checks++; if (inst_sram_addr !== 32'h1C00_0004 || inst_sram_req !== 1'b1) begin n_fail++; $display("FAIL boot_next got req=%0h addr=%0h exp req=1 addr=1c000004", inst_sram_req, inst_sram_addr); end
    n_checks++; if (fs_to_ds_valid !== 1'b0) begin n_fail++; $display("FAIL boot_bubble got %0h exp 0", fs_to_ds_valid); end
  endtask

  task automatic test_redirect_wait();
    inst_sram_addr_ok = 1'b1;
    @(negedge clk);
    inst_sram_addr_ok = 1'b0; br_taken = 1'b1; br_target = 32'h1C00_0100;
    @(negedge clk);
    br_taken = 1'b0; inst_sram_data_ok = 1'b1; inst_sram_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    inst_sram_data_ok = 1'b0; inst_sram_addr_ok = 1'b1;
    n_checks++; if (fs_to_ds_valid !== 1'b0) begin n_fail++; $display("FAIL wait_drop got %0h exp 0", fs_to_ds_valid); end
    n_checks++; if (inst_sram_addr !== 32'h1C00_0100 || inst_sram_req !== 1'b1) begin n_fail++; $display("FAIL wait_addr got req=%0h addr=%0h exp req=1 addr=1c000100", inst_sram_req, inst_sram_addr); end
    @(negedge clk);
    inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b1; inst_sram_rdata = 32'h1111_1111;
    @(negedge clk);
    inst_sram_data_ok = 1'b0;
    n_checks++; if (fs_to_ds_valid !== 1'b1 || fs_pc !== 32'h1C00_0100 || fs_inst !== 32'h1111_1111) begin n_fail++; $display("FAIL wait_deliver got v=%0h pc=%0h inst=%0h exp v=1 pc=1c000100 inst=11111111", fs_to_ds_valid, fs_pc, fs_inst); end
    @(negedge clk);
    n_checks++; if (inst_sram_addr !== 32'h1C00_0104) begin n_fail++; $display("FAIL wait_next got %0h exp 1c000104", inst_sram_addr); end
  endtask

  task automatic test_redirect_hold();
    inst_sram_addr_ok = 1'b1;
    @(negedge clk);
    inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b1; inst_sram_rdata = 32'h2222_2222;
    @(negedge clk);
    inst_sram_data_ok = 1'b0;
    n_checks++; if (fs_to_ds_valid !== 1'b1 || fs_pc !== 32'h1C00_0104) begin n_fail++; $display("FAIL hold_pre got v=%0h pc=%0h exp v=1 pc=1c000104", fs_to_ds_valid, fs_pc); end
    br_taken = 1'b1; br_target = 32'h1C00_0180; ds_allowin = 1'b1;
    #1;
    n_checks++; if (fs_to_ds_valid !== 1'b0) begin n_fail++; $display("FAIL hold_kill got %0h exp 0", fs_to_ds_valid); end
    @(negedge clk);
    br_taken = 1'b0;
    n_checks++; if (inst_sram_req !== 1'b1 || inst_sram_addr !== 32'h1C00_0180 || fs_to_ds_valid !== 1'b0) begin n_fail++; $display("FAIL hold_redirect got req=%0h addr=%0h v=%0h exp req=1 addr=1c000180 v=0", inst_sram_req, inst_sram_addr, fs_to_ds_valid); end
  endtask

  task automatic test_back_to_back();
    br_taken = 1'b1; br_target = 32'h1C00_0200;
    @(negedge clk);
    n_checks++; if (inst_sram_addr !== 32'h1C00_0180 || inst_sram_req !== 1'b1) begin n_fail++; $display("FAIL b2b_stable1 got req=%0h addr=%0h exp req=1 addr=1c000180", inst_sram_req, inst_sram_addr); end
    br_target = 32'h1C00_0300;
    @(negedge clk);
    n_checks++; if (inst_sram_addr !== 32'h1C00_0180) begin n_fail++; $display("FAIL b2b_stable2 got %0h exp 1c000180", inst_sram_addr); end
    br_taken = 1'b0; inst_sram_addr_ok = 1'b1;
    @(negedge clk);
    inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b1; inst_sram_rdata = 32'h3333_3333;
    @(negedge clk);
    inst_sram_data_ok = 1'b0; inst_sram_addr_ok = 1'b1;
    n_checks++; if (inst_sram_req !== 1'b1 || inst_sram_addr !== 32'h1C00_0300 || fs_to_ds_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_addr got req=%0h addr=%0h v=%0h exp req=1 addr=1c000300 v=0", inst_sram_req, inst_sram_addr, fs_to_ds_valid); end
    @(negedge clk);
    inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b1; inst_sram_rdata = 32'h4444_4444;
    @(negedge clk);
    inst_sram_data_ok = 1'b0;
    n_checks++; if (fs_to_ds_valid !== 1'b1 || fs_pc !== 32'h1C00_0300 || fs_inst !== 32'h4444_4444) begin n_fail++; $display("FAIL b2b_deliver got v=%0h pc=%0h inst=%0h exp v=1 pc=1c000300 inst=44444444", fs_to_ds_valid, fs_pc, fs_inst); end
    @(negedge clk);
    n_checks++; if (seen_200 !== 1'b0) begin n_fail++; $display("FAIL b2b_never_200 got %0h exp 0", seen_200); end
  endtask

  task automatic test_misaligned();
    inst_sram_addr_ok = 1'b1;
    @(negedge clk);
    inst_sram_addr_ok = 1'b0; br_taken = 1'b1; br_target = 32'h1C00_0102;
    @(negedge clk);
    br_taken = 1'b0; inst_sram_data_ok = 1'b1; inst_sram_rdata = 32'h7777_7777;
    @(negedge clk);
    inst_sram_data_ok = 1'b0; ds_allowin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (inst_sram_req !== 1'b0 || fs_to_ds_valid !== 1'b1 || fs_adef !== 1'b1 || fs_pc !== 32'h1C00_0102 || fs_inst !== 32'h0) begin n_fail++; $display("FAIL adef_slot[%0d] got req=%0h v=%0h adef=%0h pc=%0h inst=%0h exp req=0 v=1 adef=1 pc=1c000102 inst=0", i, inst_sram_req, fs_to_ds_valid, fs_adef, fs_pc, fs_inst); end
      @(negedge clk);
    end
    br_taken = 1'b1; br_target = 32'h1C00_0400;
    @(negedge clk);
    br_taken = 1'b0;
    n_checks++; if (inst_sram_req !== 1'b1 || inst_sram_addr !== 32'h1C00_0400) begin n_fail++; $display("FAIL adef_exit got req=%0h addr=%0h exp req=1 addr=1c000400", inst_sram_req, inst_sram_addr); end
  endtask

  task automatic test_backpressure();
    inst_sram_addr_ok = 1'b1;
    @(negedge clk);
    inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b1; inst_sram_rdata = 32'h5555_5555;
    @(negedge clk);
    inst_sram_data_ok = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (fs_to_ds_valid !== 1'b1 || fs_pc !== 32'h1C00_0400 || fs_inst !== 32'h5555_5555 || inst_sram_req !== 1'b0 || fs_adef !== 1'b0) begin n_fail++; $display("FAIL bp_hold[%0d] got v=%0h pc=%0h inst=%0h req=%0h adef=%0h exp v=1 pc=1c000400 inst=55555555 req=0 adef=0", i, fs_to_ds_valid, fs_pc, fs_inst, inst_sram_req, fs_adef); end
      @(negedge clk);
    end
    ds_allowin = 1'b1;
    @(negedge clk);
    n_checks++; if (inst_sram_req !== 1'b1 || inst_sram_addr !== 32'h1C00_0404 || fs_to_ds_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release got req=%0h addr=%0h v=%0h exp req=1 addr=1c000404 v=0", inst_sram_req, inst_sram_addr, fs_to_ds_valid); end
  endtask

  task automatic test_reset_mid_request();
    inst_sram_addr_ok = 1'b1;
    @(negedge clk);
    inst_sram_addr_ok = 1'b0; resetn = 1'b0;
    #1;
    n_checks++; if (inst_sram_req !== 1'b0 || fs_to_ds_valid !== 1'b0 || fs_pc !== 32'h0) begin n_fail++; $display("FAIL mid_rst got req=%0h v=%0h pc=%0h exp req=0 v=0 pc=0", inst_sram_req, fs_to_ds_valid, fs_pc); end
    @(negedge clk);
    inst_sram_data_ok = 1'b1; inst_sram_rdata = 32'h6666_6666;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    inst_sram_data_ok = 1'b0;
    n_checks++; if (fs_to_ds_valid !== 1'b0 || fs_inst !== 32'h0) begin n_fail++; $display("FAIL mid_rst_drop got v=%0h inst=%0h exp v=0 inst=0", fs_to_ds_valid, fs_inst); end
    n_checks++; if (inst_sram_req !== 1'b1 || inst_sram_addr !== 32'h1C00_0000) begin n_fail++; $display("FAIL mid_rst_boot got req=%0h addr=%0h exp req=1 addr=1c000000", inst_sram_req, inst_sram_addr); end
  endtask

  initial begin
    test_reset();
    test_redirect_wait();
    test_redirect_hold();
    test_back_to_back();
    test_misaligned();
    test_backpressure();
    test_reset_mid_request();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
